aabb_job_scheduler: RTL

AABB_JOB_SCHEDULER -- requirements
Module: aabb_job_scheduler

---
 rtl/aabb_job_scheduler_if.sv | 39 +++
 rtl/aabb_job_scheduler.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/aabb_job_scheduler_if.sv
// Job-scheduler bus: requester arbitration, job-word stream, AABB FIFO write
// port, AABB unit control/status and the per-job result strobe.
interface aabb_job_scheduler_if #(
   parameter int NUM_REQ  = 4,
   parameter int GPU_WORD = 32
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]  iReq;
   logic [NUM_REQ-1:0]  oGrant;
   logic                iJobValid;
   logic [GPU_WORD-1:0] iJobData;
   logic                oJobReady;
   logic                oFifoPush;
   logic [GPU_WORD-1:0] oFifoData;
   logic                iFifoFull;
   logic                oAabbRestart;
   logic                oAabbEnable;
   logic                iAabbDone;
   logic                iIntersectionFound;
   logic                oResultValid;
   logic [ID_W-1:0]     oResultId;
   logic                oResultHit;
   logic                oResultError;

   // Environment side: requesters, job mux, FIFO and AABB unit.
   modport master (
      output iReq, iJobValid, iJobData, iFifoFull, iAabbDone, iIntersectionFound,
      input  oGrant, oJobReady, oFifoPush, oFifoData, oAabbRestart, oAabbEnable,
             oResultValid, oResultId, oResultHit, oResultError
   );

   // Scheduler side.
   modport slave (
      input  iReq, iJobValid, iJobData, iFifoFull, iAabbDone, iIntersectionFound,
      output oGrant, oJobReady, oFifoPush, oFifoData, oAabbRestart, oAabbEnable,
             oResultValid, oResultId, oResultHit, oResultError
   );
endinterface

// File: rtl/aabb_job_scheduler.sv
// AABB job scheduler: round-robin grants one requester, streams its job words
// into the AABB input FIFO, restarts and runs the AABB unit with a timeout,
// then reports hit/error for that requester before arbitrating again.
module aabb_job_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int WORDS_PER_JOB = 9,
   parameter int TIMEOUT       = 255,
   parameter int GPU_WORD      = 32
) (
   input  logic                iClock,
   input  logic                iReset,
   aabb_job_scheduler_if.slave bus
);
   localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int WCNT_W = $clog2(WORDS_PER_JOB + 1);
   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_RUN,
      S_REPORT
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ID_W-1:0]     r_rr;
   logic [ID_W-1:0]     r_gidx;
   logic [NUM_REQ-1:0]  r_grant;
   logic [WCNT_W-1:0]   r_wcnt;
   logic [TCNT_W-1:0]   r_tcnt;
   logic                r_hit;
   logic [ID_W-1:0]     r_res_id;
   logic                r_res_hit;
   logic                r_res_err;

   logic                w_req_any;
   logic [ID_W-1:0]     w_pick;
   logic                w_push;
   logic                w_last_word;
   logic [TCNT_W-1:0]   w_tcnt_inc;
   logic                w_timeout;
   logic                w_job_ready;
   logic [GPU_WORD-1:0] w_fifo_data;
   logic                w_restart;
   logic                w_enable;
   logic                w_result_valid;

   // Round-robin pick: first requesting index at or after r_rr, wrapping.
   always_comb begin
      w_req_any = 1'b0;
      w_pick    = r_rr;
      // Walk offsets from farthest to nearest so the nearest requester wins.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         int idx;
         idx = int'(r_rr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (bus.iReq[idx]) begin
            w_req_any = 1'b1;
            w_pick    = ID_W'(idx);
         end
      end
   end

   // Next-state and combinational outputs for the job sequence.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      w_state_nxt    = r_state;
      w_push         = 1'b0;
      w_last_word    = 1'b0;
      w_job_ready    = 1'b0;
      w_fifo_data    = '0;
      w_restart      = 1'b0;
      w_enable       = 1'b0;
      w_result_valid = 1'b0;
      // RUN-cycle count including the current cycle; reaching TIMEOUT aborts.
      w_tcnt_inc     = r_tcnt + 1'b1;
      w_timeout      = (w_tcnt_inc == TCNT_W'(TIMEOUT));
      unique case (r_state)
         S_IDLE: begin
            if (w_req_any) w_state_nxt = S_LOAD;
         end
         S_LOAD: begin
            w_job_ready = ~bus.iFifoFull;
            w_push      = bus.iJobValid & ~bus.iFifoFull;
            w_fifo_data = bus.iJobData;
            w_last_word = (r_wcnt == WCNT_W'(WORDS_PER_JOB - 1));
            if (w_push && w_last_word) w_state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            w_restart   = 1'b1;
            w_state_nxt = S_RUN;
         end
         S_RUN: begin
            w_enable = 1'b1;
            if (bus.iAabbDone || w_timeout) w_state_nxt = S_REPORT;
         end
         S_REPORT: begin
            w_result_valid = 1'b1;
            w_state_nxt    = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge iClock or negedge iReset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      if (!iReset) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Grant, counters, sticky hit flag and held result registers.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         r_rr      <= '0;
         r_gidx    <= '0;
         r_grant   <= '0;
         r_wcnt    <= '0;
         r_tcnt    <= '0;
         r_hit     <= 1'b0;
         r_res_id  <= '0;
         r_res_hit <= 1'b0;
         r_res_err <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_req_any) begin
                  r_grant <= NUM_REQ'(1) << w_pick;
                  r_gidx  <= w_pick;
                  r_wcnt  <= '0;
               end
            end
            S_LOAD: begin
               if (w_push) r_wcnt <= w_last_word ? '0 : r_wcnt + 1'b1;
            end
            S_CLEAR: begin
               r_hit  <= 1'b0;
               r_tcnt <= '0;
            end
            S_RUN: begin
               r_tcnt <= w_tcnt_inc;
               r_hit  <= r_hit | bus.iIntersectionFound;
               // Done wins over a coinciding timeout.
               if (bus.iAabbDone) begin
                  r_res_id  <= r_gidx;
                  r_res_hit <= r_hit | bus.iIntersectionFound;
                  r_res_err <= 1'b0;
               end else if (w_timeout) begin
                  r_res_id  <= r_gidx;
                  r_res_hit <= 1'b0;
                  r_res_err <= 1'b1;
               end
            end
            S_REPORT: begin
               r_grant <= '0;
               r_rr    <= (int'(r_gidx) == NUM_REQ - 1) ? '0 : r_gidx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bus.oGrant       = r_grant;
   assign bus.oJobReady    = w_job_ready;
   assign bus.oFifoPush    = w_push;
   assign bus.oFifoData    = w_fifo_data;
   assign bus.oAabbRestart = w_restart;
   assign bus.oAabbEnable  = w_enable;
   assign bus.oResultValid = w_result_valid;
   assign bus.oResultId    = r_res_id;
   assign bus.oResultHit   = r_res_hit;
   assign bus.oResultError = r_res_err;
endmodule
